oc8051_alu_arbiter: RTL and testbench
=====================================

// Module: oc8051_alu_arbiter
// PURPOSE
//  Shares one oc8051_alu instance between NUM_REQ requesters (e.g. core pipe, BIST, debug port).
//  Round-robin arbitration; captures the granted op and drives it to the ALU for a fixed latency.
//  Captures the ALU results and returns them with the requester ID over a valid/ready response channel.
//  Sits between the requesters and the ALU; the ALU's clk/rst come from the same clk/rst.
// PARAMETERS
//  NUM_REQ     2     number of requesters, legal range 2..8
//  ALU_LAT     1     cycles operands are held for ordinary ops before result capture (>=1)
//  MULDIV_LAT  4     cycles operands are held for MUL/DIV before result capture (>=1)
//  MUL_OP      4'h6  op_code treated as multiply
//  DIV_OP      4'h7  op_code treated as divide
//  (ID_W = $clog2(NUM_REQ), derived)
// PORTS
//  clk          in   1            clock, all logic on rising edge
//  rst          in   1            synchronous, active-high reset
//  req_valid    in   NUM_REQ      per-requester op valid
//  req_ready    out  NUM_REQ      one-hot accept pulse
//  req_op_code  in   4*NUM_REQ    packed op codes, requester i at [4i+:4]
//  req_src1/2/3 in   8*NUM_REQ    packed operands, requester i at [8i+:8]
//  req_cy/ac/bit in  NUM_REQ      carry-in, aux-carry-in, bit_in per requester
//  alu_op_code  out  4            to ALU op_code
//  alu_src1/2/3 out  8            to ALU src1/src2/src3
//  alu_cy/ac/bit out 1            to ALU srcCy/srcAc/bit_in
//  alu_des1/des2/des_acc in 8     from ALU
//  alu_desCy/desAc/desOv in 1     from ALU
//  alu_sub_result in 8            from ALU
//  resp_valid   out  1            response valid
//  resp_ready   in   1            response accept
//  resp_id      out  ID_W         index of the requester that issued the op
//  resp_des1/des2/des_acc out 8   captured ALU results
//  resp_cy/ac/ov out 1            captured flags
//  resp_sub     out  8            captured sub_result
// BEHAVIOUR
//  FSM IDLE -> EXEC -> RESP -> IDLE. Reset: state IDLE, rr_ptr=0, cnt=0.
//  Reset values: req_ready=0, resp_valid=0, all resp_* =0, all alu_* =0 (op 0, operands 0).
//  IDLE: if any req_valid, grant the first set bit at or after rr_ptr (circular).
//   req_ready[g]=1 combinationally in that cycle only; the op/operands of g are registered.
//   rr_ptr <= (g+1) mod NUM_REQ. Go to EXEC; cnt <= lat-1.
//   lat = MULDIV_LAT if op==MUL_OP or DIV_OP, else ALU_LAT.
//  EXEC: alu_* driven from the captured registers, stable every cycle.
//   cnt decrements; when cnt==0 capture all alu_des*/flags/sub_result and resp_id, then go to RESP.
//  RESP: resp_valid=1, resp_* held stable until resp_ready; on handshake go to IDLE.
//   req_ready=0 throughout EXEC and RESP.
//  Latency: accept at cycle T; resp_valid first high at T+lat+1. No back-to-back issue:
//   after the response handshake, the next accept occurs at the earliest one cycle later (IDLE).
//  alu_* keep the last op's values in RESP/IDLE; they return to 0 only on reset.
//  Requester must hold req_* stable while req_valid=1 and not accepted. Dropping valid is allowed; no grant results.
//  rst mid-EXEC/RESP: op discarded, no response, every register takes its reset value next cycle.
//  resp_ready while !resp_valid is ignored. An ID >= NUM_REQ is never produced.
// TESTING
//  1. Req0 ADD (4'h1) src1=8'h3C src2=8'h05 cy=0, ALU_LAT=1 -> req_ready[0] at T; resp_valid at T+2,
//     resp_id=0, resp_des_acc=8'h41, resp_cy=0.
//  2. Req0 and req1 valid together from reset, ops held -> grants 0,1,0,1...
//     Never twice in a row while the other requester is still waiting.
//  3. Req1 MUL (4'h6) src1=8'h10 src2=8'h10, MULDIV_LAT=4 -> alu_* stable 4 cycles; resp_valid at T+5;
//     resp_des_acc=8'h00, resp_des2=8'h01, resp_ov=1.
//  4. Hold resp_ready=0 for 10 cycles -> resp_* constant, req_ready stays 0, no new grant; accept 1 cycle after the handshake.
//  5. Assert rst in the 2nd EXEC cycle of a MUL -> next cycle state IDLE, resp_valid=0, alu_op_code=0, rr_ptr=0.
//  6. NUM_REQ=3; only req2 valid -> granted immediately; rr_ptr wraps to 0; next grant goes to req0 if valid.

Source files
------------

// File: rtl/oc8051_alu_arbiter.sv
// oc8051_alu_arbiter: shares one oc8051_alu between NUM_REQ requesters.
// A round-robin grant captures one requester's op and operands. They are held
// on the ALU for a fixed latency, the ALU results are captured, and the
// results are returned with the requester index on a valid/ready channel.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   req_valid_i / req_ready_o      per-requester request; ready is a one-hot
//                                  accept pulse, combinational in IDLE
//   req_op_code_i                  packed op codes, requester i at [4i+:4]
//   req_src1/2/3_i                 packed operands, requester i at [8i+:8]
//   req_cy/ac/bit_i                per-requester carry, aux carry, bit in
//   alu_*_o                        registered op and operands to the ALU
//   alu_des*/sub_result_i          ALU results
//   resp_valid_o / resp_ready_i    response handshake
//   resp_id_o, resp_*_o            captured requester index and ALU results
module oc8051_alu_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned MULDIV_LAT = 4,
  parameter logic [3:0]  MUL_OP     = 4'h6,
  parameter logic [3:0]  DIV_OP     = 4'h7,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [4*NUM_REQ-1:0] req_op_code_i,
  input  logic [8*NUM_REQ-1:0] req_src1_i,
  input  logic [8*NUM_REQ-1:0] req_src2_i,
  input  logic [8*NUM_REQ-1:0] req_src3_i,
  input  logic [NUM_REQ-1:0]   req_cy_i,
  input  logic [NUM_REQ-1:0]   req_ac_i,
  input  logic [NUM_REQ-1:0]   req_bit_i,
  output logic [3:0]           alu_op_code_o,
  output logic [7:0]           alu_src1_o,
  output logic [7:0]           alu_src2_o,
  output logic [7:0]           alu_src3_o,
  output logic                 alu_cy_o,
  output logic                 alu_ac_o,
  output logic                 alu_bit_o,
  input  logic [7:0]           alu_des1_i,
  input  logic [7:0]           alu_des2_i,
  input  logic [7:0]           alu_des_acc_i,
  input  logic                 alu_des_cy_i,
  input  logic                 alu_des_ac_i,
  input  logic                 alu_des_ov_i,
  input  logic [7:0]           alu_sub_result_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [ID_W-1:0]      resp_id_o,
  output logic [7:0]           resp_des1_o,
  output logic [7:0]           resp_des2_o,
  output logic [7:0]           resp_des_acc_o,
  output logic                 resp_cy_o,
  output logic                 resp_ac_o,
  output logic                 resp_ov_o,
  output logic [7:0]           resp_sub_o
);

  localparam int unsigned MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q, id_q, resp_id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        op_q;
  logic [7:0]        src1_q, src2_q, src3_q;
  logic              cy_q, ac_q, bit_q;
  logic              resp_valid_q;
  logic [7:0]        des1_q, des2_q, acc_q, sub_q;
  logic              rcy_q, rac_q, rov_q;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx, scan_idx;
  logic [3:0]        sel_op;
  logic [7:0]        sel_src1, sel_src2, sel_src3;
  logic              sel_cy, sel_ac, sel_bit;
  logic [CNT_W-1:0]  cnt_load;

  // Circular scan for the first valid requester at or after rr_ptr_q
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(rr_ptr_q) + k >= NUM_REQ) scan_idx = ID_W'(32'(rr_ptr_q) + k - NUM_REQ);
      else                              scan_idx = ID_W'(32'(rr_ptr_q) + k);
      if (!grant_vld && req_valid_i[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Payload mux of the granted requester
  always_comb begin
    sel_op   = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    sel_src3 = '0;
    sel_cy   = 1'b0;
    sel_ac   = 1'b0;
    sel_bit  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op   = req_op_code_i[4*i +: 4];
        sel_src1 = req_src1_i[8*i +: 8];
        sel_src2 = req_src2_i[8*i +: 8];
        sel_src3 = req_src3_i[8*i +: 8];
        sel_cy   = req_cy_i[i];
        sel_ac   = req_ac_i[i];
        sel_bit  = req_bit_i[i];
      end
    end
  end

  assign cnt_load = (sel_op == MUL_OP || sel_op == DIV_OP) ? CNT_W'(MULDIV_LAT - 1)
                                                            : CNT_W'(ALU_LAT - 1);

  // Accept pulse only in the grant cycle; suppressed while reset is applied
  assign req_ready_o = (state_q == S_IDLE && grant_vld && !rst)
                     ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      src3_q       <= '0;
      cy_q         <= 1'b0;
      ac_q         <= 1'b0;
      bit_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      des1_q       <= '0;
      des2_q       <= '0;
      acc_q        <= '0;
      sub_q        <= '0;
      rcy_q        <= 1'b0;
      rac_q        <= 1'b0;
      rov_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            op_q     <= sel_op;
            src1_q   <= sel_src1;
            src2_q   <= sel_src2;
            src3_q   <= sel_src3;
            cy_q     <= sel_cy;
            ac_q     <= sel_ac;
            bit_q    <= sel_bit;
            id_q     <= grant_idx;
            cnt_q    <= cnt_load;
            rr_ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            des1_q       <= alu_des1_i;
            des2_q       <= alu_des2_i;
            acc_q        <= alu_des_acc_i;
            sub_q        <= alu_sub_result_i;
            rcy_q        <= alu_des_cy_i;
            rac_q        <= alu_des_ac_i;
            rov_q        <= alu_des_ov_i;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_op_code_o  = op_q;
  assign alu_src1_o     = src1_q;
  assign alu_src2_o     = src2_q;
  assign alu_src3_o     = src3_q;
  assign alu_cy_o       = cy_q;
  assign alu_ac_o       = ac_q;
  assign alu_bit_o      = bit_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_id_o      = resp_id_q;
  assign resp_des1_o    = des1_q;
  assign resp_des2_o    = des2_q;
  assign resp_des_acc_o = acc_q;
  assign resp_sub_o     = sub_q;
  assign resp_cy_o      = rcy_q;
  assign resp_ac_o      = rac_q;
  assign resp_ov_o      = rov_q;

endmodule

// File: tb/tb_oc8051_alu_arbiter.sv
// Self-checking bench for oc8051_alu_arbiter with three requesters and a
// behavioural ALU stand-in. Expected grants, latencies and results come from
// a reference model of the arbitration rules and plain ALU arithmetic.
module tb_oc8051_alu_arbiter;
  localparam int N = 3;

  typedef struct packed {
    logic [7:0] des1;
    logic [7:0] des2;
    logic [7:0] acc;
    logic [7:0] sub;
    logic       cy;
    logic       ac;
    logic       ov;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [4*N-1:0]   req_op_code;
  logic [8*N-1:0]   req_src1, req_src2, req_src3;
  logic [N-1:0]     req_cy = '0, req_ac = '0, req_bit = '0;
  logic [3:0]       op_a [N];
  logic [7:0]       a_a [N];
  logic [7:0]       b_a [N];
  logic [7:0]       c_a [N];

  logic [3:0] alu_op_code;
  logic [7:0] alu_src1, alu_src2, alu_src3;
  logic       alu_cy, alu_ac, alu_bit;
  logic [7:0] alu_des1, alu_des2, alu_des_acc, alu_sub_result;
  logic       alu_des_cy, alu_des_ac, alu_des_ov;

  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [1:0] resp_id;
  logic [7:0] resp_des1, resp_des2, resp_des_acc, resp_sub;
  logic       resp_cy, resp_ac, resp_ov;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_op_code[4*g +: 4] = op_a[g];
    assign req_src1[8*g +: 8]    = a_a[g];
    assign req_src2[8*g +: 8]    = b_a[g];
    assign req_src3[8*g +: 8]    = c_a[g];
  end

  // Behavioural ALU: ADD, MUL, DIV plus simple pass-through for other ops
  function automatic res_t alu_fn(input logic [3:0] op, input logic [7:0] a, b, c,
                                  input logic cy, ac, bt);
    res_t r;
    logic [8:0]  s;
    logic [15:0] p;
    s = '0;
    p = '0;
    r.des1 = c ^ {7'd0, bt};
    r.des2 = c;
    r.sub  = a - b;
    r.acc  = a ^ b;
    r.cy   = cy;
    r.ac   = ac;
    r.ov   = 1'b0;
    case (op)
      4'h1: begin
        s    = {1'b0, a} + {1'b0, b} + {8'd0, cy};
        r.acc = s[7:0];
        r.cy  = s[8];
        r.ac  = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cy}) > 5'd15;
        r.ov  = (a[7] == b[7]) && (s[7] != a[7]);
      end
      4'h6: begin
        p     = {8'd0, a} * {8'd0, b};
        r.acc  = p[7:0];
        r.des2 = p[15:8];
        r.ov   = |p[15:8];
        r.cy   = 1'b0;
      end
      4'h7: begin
        r.cy = 1'b0;
        if (b == 8'd0) begin
          r.acc = 8'd0; r.des2 = 8'd0; r.ov = 1'b1;
        end else begin
          r.acc = a / b; r.des2 = a % b; r.ov = 1'b0;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  res_t ar;
  always_comb ar = alu_fn(alu_op_code, alu_src1, alu_src2, alu_src3, alu_cy, alu_ac, alu_bit);
  assign alu_des1       = ar.des1;
  assign alu_des2       = ar.des2;
  assign alu_des_acc    = ar.acc;
  assign alu_sub_result = ar.sub;
  assign alu_des_cy     = ar.cy;
  assign alu_des_ac     = ar.ac;
  assign alu_des_ov     = ar.ov;

  oc8051_alu_arbiter #(.NUM_REQ(N), .ALU_LAT(1), .MULDIV_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_code_i(req_op_code), .req_src1_i(req_src1), .req_src2_i(req_src2),
    .req_src3_i(req_src3), .req_cy_i(req_cy), .req_ac_i(req_ac), .req_bit_i(req_bit),
    .alu_op_code_o(alu_op_code), .alu_src1_o(alu_src1), .alu_src2_o(alu_src2),
    .alu_src3_o(alu_src3), .alu_cy_o(alu_cy), .alu_ac_o(alu_ac), .alu_bit_o(alu_bit),
    .alu_des1_i(alu_des1), .alu_des2_i(alu_des2), .alu_des_acc_i(alu_des_acc),
    .alu_des_cy_i(alu_des_cy), .alu_des_ac_i(alu_des_ac), .alu_des_ov_i(alu_des_ov),
    .alu_sub_result_i(alu_sub_result),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_des1_o(resp_des1), .resp_des2_o(resp_des2), .resp_des_acc_o(resp_des_acc),
    .resp_cy_o(resp_cy), .resp_ac_o(resp_ac), .resp_ov_o(resp_ov), .resp_sub_o(resp_sub)
  );

  // Reference arbitration: first valid requester at or after the pointer, circularly
  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (op == 4'h6 || op == 4'h7) ? 4 : 1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic res_t exp_of(input int r);
    return alu_fn(op_a[r], a_a[r], b_a[r], c_a[r], req_cy[r], req_ac[r], req_bit[r]);
  endfunction

  function automatic res_t got_res();
    return {resp_des1, resp_des2, resp_des_acc, resp_sub, resp_cy, resp_ac, resp_ov};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [7:0] a, b, c,
                         input logic cy, ac, bt);
    op_a[r] = op; a_a[r] = a; b_a[r] = b; c_a[r] = c;
    req_cy[r] = cy; req_ac[r] = ac; req_bit[r] = bt;
    req_valid[r] = 1'b1;
  endtask

  task automatic set_rand(input int r);
    logic [3:0] op;
    case ($urandom_range(0, 3))
      0:       op = 4'h1;
      1:       op = 4'h6;
      2:       op = 4'h7;
      default: op = 4'($urandom_range(0, 15));
    endcase
    set_req(r, op, 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Clock the accept edge, drop the given valids, then count cycles to resp_valid (bounded)
  task automatic accept_wait(input logic [N-1:0] drop, output int n);
    tick();
    req_valid = req_valid & ~drop;
    n = 1;
    while (resp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_rr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, got_res()} !== '0) begin
      errors++;
      $display("FAIL reset_resp got ready=%b valid=%b id=%0d res=%h exp all zero",
               req_ready, resp_valid, resp_id, got_res());
    end
    checks++;
    if ({alu_op_code, alu_src1, alu_src2, alu_src3, alu_cy, alu_ac, alu_bit} !== '0) begin
      errors++;
      $display("FAIL reset_alu got op=%h s1=%h s2=%h s3=%h exp all zero",
               alu_op_code, alu_src1, alu_src2, alu_src3);
    end
    do_reset();
  endtask

  task automatic test_add();
    int n;
    set_req(0, 4'h1, 8'h3C, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL add_ready got %b exp 001", req_ready);
    end
    accept_wait(3'b111, n);
    m_rr = 1;
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL add_latency got %0d exp 2", n);
    end
    checks++;
    if (resp_id !== 2'd0 || resp_des_acc !== 8'h41 || resp_cy !== 1'b0) begin
      errors++;
      $display("FAIL add_result got id=%0d acc=%h cy=%b exp id=0 acc=41 cy=0",
               resp_id, resp_des_acc, resp_cy);
    end
    handshake();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL add_resp_drop got %b exp 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int n, g;
    res_t e;
    logic [N-1:0] last_oh;
    do_reset();
    last_oh = '0;
    set_req(0, 4'h1, 8'($urandom), 8'($urandom), 8'h11, 1'b1, 1'b0, 1'b0);
    set_req(1, 4'h2, 8'($urandom), 8'($urandom), 8'h22, 1'b0, 1'b1, 1'b1);
    for (int it = 0; it < 6; it++) begin
      #1;
      g = pick(req_valid, m_rr);
      checks++;
      if (req_ready !== onehot(g) || req_ready === last_oh) begin
        errors++;
        $display("FAIL rr_grant it=%0d got %b exp %b prev %b", it, req_ready, onehot(g), last_oh);
      end
      last_oh = req_ready;
      e = exp_of(g);
      accept_wait('0, n);
      m_rr = (g + 1) % N;
      checks++;
      if (n != lat_of(op_a[g]) + 1 || resp_id !== 2'(g) || got_res() !== e) begin
        errors++;
        $display("FAIL rr_resp it=%0d got lat=%0d id=%0d res=%h exp lat=%0d id=%0d res=%h",
                 it, n, resp_id, got_res(), lat_of(op_a[g]) + 1, g, e);
      end
      handshake();
    end
    req_valid = '0;
  endtask

  task automatic test_mul();
    set_req(1, 4'h6, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL mul_ready got %b exp 010", req_ready);
    end
    tick();
    req_valid = '0;
    m_rr = 2;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (alu_op_code !== 4'h6 || alu_src1 !== 8'h10 || alu_src2 !== 8'h10 ||
          resp_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL mul_exec k=%0d got op=%h s1=%h s2=%h valid=%b ready=%b exp op=6 s1=10 s2=10 valid=0 ready=000",
                 k, alu_op_code, alu_src1, alu_src2, resp_valid, req_ready);
      end
      tick();
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_des_acc !== 8'h00 ||
        resp_des2 !== 8'h01 || resp_ov !== 1'b1) begin
      errors++;
      $display("FAIL mul_result got valid=%b id=%0d acc=%h des2=%h ov=%b exp valid=1 id=1 acc=00 des2=01 ov=1",
               resp_valid, resp_id, resp_des_acc, resp_des2, resp_ov);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int n, g;
    res_t e;
    set_req(0, 4'h1, 8'hF0, 8'h20, 8'h5A, 1'b1, 1'b0, 1'b1);
    #1;
    g = pick(req_valid, m_rr);
    e = exp_of(g);
    accept_wait(3'b111, n);
    m_rr = (g + 1) % N;
    set_req(1, 4'h7, 8'd200, 8'd7, 8'h00, 1'b0, 1'b0, 1'b0);
    set_req(2, 4'h1, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(g) || got_res() !== e || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold k=%0d got valid=%b id=%0d res=%h ready=%b exp valid=1 id=%0d res=%h ready=000",
                 k, resp_valid, resp_id, got_res(), req_ready, g, e);
      end
      tick();
    end
    handshake();
    #1;
    g = pick(req_valid, m_rr);
    checks++;
    if (req_ready !== onehot(g)) begin
      errors++; $display("FAIL bp_next_grant got %b exp %b", req_ready, onehot(g));
    end
    e = exp_of(g);
    accept_wait(3'b111, n);
    m_rr = (g + 1) % N;
    checks++;
    if (n != lat_of(op_a[g]) + 1 || resp_id !== 2'(g) || got_res() !== e) begin
      errors++;
      $display("FAIL bp_next_resp got lat=%0d id=%0d res=%h exp lat=%0d id=%0d res=%h",
               n, resp_id, got_res(), lat_of(op_a[g]) + 1, g, e);
    end
    handshake();
  endtask

  task automatic test_reset_mid_exec();
    int n;
    res_t e;
    req_valid = '0;
    set_req(1, 4'h6, 8'h33, 8'h44, 8'h00, 1'b1, 1'b1, 1'b1);
    #1;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (resp_valid !== 1'b0 || alu_op_code !== 4'h0 || alu_src1 !== 8'h00 || req_ready !== '0) begin
      errors++;
      $display("FAIL rst_exec got valid=%b op=%h s1=%h ready=%b exp 0 0 00 000",
               resp_valid, alu_op_code, alu_src1, req_ready);
    end
    rst = 1'b0;
    m_rr = 0;
    set_req(1, 4'h1, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
    set_req(2, 4'h1, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL rst_ptr_grant got %b exp 010", req_ready);
    end
    e = exp_of(1);
    accept_wait(3'b111, n);
    m_rr = 2;
    checks++;
    if (n != 2 || resp_id !== 2'd1 || got_res() !== e) begin
      errors++;
      $display("FAIL rst_after_resp got lat=%0d id=%0d res=%h exp lat=2 id=1 res=%h",
               n, resp_id, got_res(), e);
    end
    handshake();
  endtask

  task automatic test_wrap();
    int n;
    res_t e;
    do_reset();
    set_req(2, 4'h1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL wrap_req2 got %b exp 100", req_ready);
    end
    accept_wait(3'b111, n);
    m_rr = 0;
    handshake();
    set_req(0, 4'h1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    set_req(1, 4'h1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
    set_req(2, 4'h1, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL wrap_to_req0 got %b exp 001", req_ready);
    end
    e = exp_of(0);
    accept_wait(3'b111, n);
    m_rr = 1;
    checks++;
    if (resp_id !== 2'd0 || got_res() !== e) begin
      errors++;
      $display("FAIL wrap_resp got id=%0d res=%h exp id=0 res=%h", resp_id, got_res(), e);
    end
    handshake();
  endtask

  task automatic test_random();
    int n, g, d;
    res_t e;
    logic [N-1:0] mask;
    for (int it = 0; it < 30; it++) begin
      mask = N'($urandom_range(1, 7));
      for (int r = 0; r < N; r++) if (mask[r]) set_rand(r);
      #1;
      g = pick(req_valid, m_rr);
      checks++;
      if (req_ready !== onehot(g)) begin
        errors++; $display("FAIL rnd_grant it=%0d got %b exp %b", it, req_ready, onehot(g));
      end
      e = exp_of(g);
      resp_ready = 1'($urandom);
      accept_wait(3'b111, n);
      m_rr = (g + 1) % N;
      checks++;
      if (n != lat_of(op_a[g]) + 1 || resp_id !== 2'(g) || got_res() !== e) begin
        errors++;
        $display("FAIL rnd_resp it=%0d got lat=%0d id=%0d res=%h exp lat=%0d id=%0d res=%h",
                 it, n, resp_id, got_res(), lat_of(op_a[g]) + 1, g, e);
      end
      if (resp_ready) begin
        tick();
        resp_ready = 1'b0;
      end else begin
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) tick();
        checks++;
        if (resp_valid !== 1'b1 || got_res() !== e) begin
          errors++;
          $display("FAIL rnd_hold it=%0d got valid=%b res=%h exp valid=1 res=%h",
                   it, resp_valid, got_res(), e);
        end
        handshake();
      end
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL rnd_drop it=%0d got %b exp 0", it, resp_valid);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < N; r++) begin
      op_a[r] = '0; a_a[r] = '0; b_a[r] = '0; c_a[r] = '0;
    end
    test_reset();
    test_add();
    test_round_robin();
    test_mul();
    test_backpressure();
    test_reset_mid_exec();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
